// File: rtl/dma_pcie_msix_pkg.sv
// Shared types for the MSI-X issue engine: FSM states, completion codes and
// the channel-index width helper.
package dma_pcie_msix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DONE_SENT    = 2'd0,
        DONE_FAIL    = 2'd1,
        DONE_TIMEOUT = 2'd2
    } done_code_t;

    // A single channel still needs a one-bit index.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/dma_pcie_rr_arb.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps modulo
// NUM_CH; the first requester found wins.
module dma_pcie_rr_arb
    import dma_pcie_msix_pkg::*;
#(
    parameter  int NUM_CH = 8,
    localparam int CH_W   = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx,
    output logic              any
);

    function automatic logic [CH_W-1:0] wrap(input logic [CH_W-1:0] p, input int off);
        return CH_W'((int'(p) + off) % NUM_CH);
    endfunction

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!any && req[wrap(ptr, i)]) begin
                any               = 1'b1;
                idx               = wrap(ptr, i);
                grant[wrap(ptr, i)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_pcie_msix_arb.sv
// Multi-channel MSI-X issue engine: round-robin accept, one message in flight,
// retry on core fail, timeout, and a per-request completion strobe.
module dma_pcie_msix_arb
    import dma_pcie_msix_pkg::*;
#(
    parameter  int NUM_CH    = 8,
    parameter  int FUNC_W    = 8,
    parameter  int MAX_RETRY = 3,
    parameter  int TIMEOUT   = 1023,
    localparam int CH_W      = ch_w(NUM_CH)
) (
    input  logic                     user_clk,
    input  logic                     user_reset,
    input  logic [NUM_CH-1:0]        req_vld,
    output logic [NUM_CH-1:0]        req_rdy,
    input  logic [NUM_CH*64-1:0]     req_addr,
    input  logic [NUM_CH*32-1:0]     req_data,
    input  logic [NUM_CH*FUNC_W-1:0] req_func,
    output logic                     done_vld,
    output logic [CH_W-1:0]          done_ch,
    output logic [1:0]               done_code,
    output logic                     busy,
    input  logic                     cfg_interrupt_msix_enable,
    input  logic                     cfg_interrupt_msix_mask,
    output logic                     cfg_interrupt_msix_int,
    output logic [63:0]              cfg_interrupt_msix_address,
    output logic [31:0]              cfg_interrupt_msix_data,
    output logic [FUNC_W-1:0]        cfg_interrupt_msi_function_number,
    input  logic                     cfg_interrupt_msi_sent,
    input  logic                     cfg_interrupt_msi_fail
);

    state_t            state, next_state;
    logic [CH_W-1:0]   rr_ptr, cap_ch, win_idx;
    logic [NUM_CH-1:0] arb_req, win_grant;
    logic              win_any, arb_open;
    logic [3:0]        retry_cnt;
    logic [15:0]       tmo_cnt;
    logic              tmo_hit, can_retry;
    done_code_t        code_d;
    logic              msix_int_d, done_vld_d, busy_d;

    // Grants are only offered from IDLE while the host allows MSI-X.
    assign arb_open = (state == ST_IDLE) && cfg_interrupt_msix_enable && !cfg_interrupt_msix_mask;
    assign arb_req  = arb_open ? req_vld : '0;

    dma_pcie_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .req   (arb_req),
        .ptr   (rr_ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign req_rdy   = win_grant;
    assign tmo_hit   = (tmo_cnt == 16'(TIMEOUT - 1));
    assign can_retry = (retry_cnt < 4'(MAX_RETRY));

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge user_clk) begin
        if (user_reset) state <= ST_IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:  if (win_any) next_state = ST_ISSUE;
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT: begin
                if (cfg_interrupt_msi_fail)
                    next_state = can_retry ? ST_ISSUE : ST_DONE;
                else if (cfg_interrupt_msi_sent || tmo_hit)
                    next_state = ST_DONE;
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each appears
    // in the cycle the FSM occupies that state. Fail outranks sent.
    always_comb begin
        msix_int_d = (next_state == ST_ISSUE);
        done_vld_d = (next_state == ST_DONE);
        busy_d     = (next_state != ST_IDLE);
        code_d     = DONE_TIMEOUT;
        if (cfg_interrupt_msi_fail)      code_d = DONE_FAIL;
        else if (cfg_interrupt_msi_sent) code_d = DONE_SENT;
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            cfg_interrupt_msix_int            <= 1'b0;
            done_vld                          <= 1'b0;
            busy                              <= 1'b0;
            done_ch                           <= '0;
            done_code                         <= '0;
            cfg_interrupt_msix_address        <= '0;
            cfg_interrupt_msix_data           <= '0;
            cfg_interrupt_msi_function_number <= '0;
        end else begin
            cfg_interrupt_msix_int <= msix_int_d;
            done_vld               <= done_vld_d;
            busy                   <= busy_d;
            if (done_vld_d) begin
                done_ch   <= cap_ch;
                done_code <= code_d;
            end
            if (win_any) begin
                cfg_interrupt_msix_address        <= req_addr[64*int'(win_idx) +: 64];
                cfg_interrupt_msix_data           <= req_data[32*int'(win_idx) +: 32];
                cfg_interrupt_msi_function_number <= req_func[FUNC_W*int'(win_idx) +: FUNC_W];
            end
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            rr_ptr    <= '0;
            cap_ch    <= '0;
            retry_cnt <= '0;
            tmo_cnt   <= '0;
        end else begin
            if (win_any) begin
                cap_ch    <= win_idx;
                retry_cnt <= '0;
                rr_ptr    <= (win_idx == CH_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
            end
            if (state == ST_WAIT && cfg_interrupt_msi_fail && can_retry)
                retry_cnt <= retry_cnt + 1'b1;
            if (state == ST_ISSUE)
                tmo_cnt <= '0;
            else if (state == ST_WAIT)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dma_pcie_msix_arb.sv
// Self-checking bench for dma_pcie_msix_arb: a core responder model, a monitor
// popping expected pulses/completions from scoreboard queues, and scenario tasks.
module tb_dma_pcie_msix_arb;
    import dma_pcie_msix_pkg::*;

    localparam int NUM_CH    = 8;
    localparam int FUNC_W    = 8;
    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT   = 16;
    localparam int CH_W      = ch_w(NUM_CH);

    localparam int M_SENT      = 0;
    localparam int M_FAIL      = 1;
    localparam int M_SILENT    = 2;
    localparam int M_BOTH_ONCE = 3;

    typedef struct {
        logic [63:0]       addr;
        logic [31:0]       data;
        logic [FUNC_W-1:0] func;
    } msg_t;

    typedef struct {
        int ch;
        int code;
    } cpl_t;

    logic                     user_clk = 1'b0;
    logic                     user_reset;
    logic [NUM_CH-1:0]        req_vld, req_rdy;
    logic [NUM_CH*64-1:0]     req_addr;
    logic [NUM_CH*32-1:0]     req_data;
    logic [NUM_CH*FUNC_W-1:0] req_func;
    logic                     done_vld;
    logic [CH_W-1:0]          done_ch;
    logic [1:0]               done_code;
    logic                     busy;
    logic                     msix_enable, msix_mask, msix_int;
    logic [63:0]              msix_addr;
    logic [31:0]              msix_data;
    logic [FUNC_W-1:0]        msix_func;
    logic                     msi_sent, msi_fail;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   pulse_total = 0;
    int   last_pulse_cyc = 0;
    int   last_done_cyc  = 0;
    int   resp_mode  = M_SENT;
    int   resp_delay = 1;
    int   both_left  = 0;
    msg_t pulse_q[$];
    cpl_t done_q[$];
    int   grant_log[$];
    int   grant_cyc[$];
    msg_t mon_msg;
    cpl_t mon_cpl;

    dma_pcie_msix_arb #(
        .NUM_CH(NUM_CH), .FUNC_W(FUNC_W), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)
    ) dut (
        .user_clk                          (user_clk),
        .user_reset                        (user_reset),
        .req_vld                           (req_vld),
        .req_rdy                           (req_rdy),
        .req_addr                          (req_addr),
        .req_data                          (req_data),
        .req_func                          (req_func),
        .done_vld                          (done_vld),
        .done_ch                           (done_ch),
        .done_code                         (done_code),
        .busy                              (busy),
        .cfg_interrupt_msix_enable         (msix_enable),
        .cfg_interrupt_msix_mask           (msix_mask),
        .cfg_interrupt_msix_int            (msix_int),
        .cfg_interrupt_msix_address        (msix_addr),
        .cfg_interrupt_msix_data           (msix_data),
        .cfg_interrupt_msi_function_number (msix_func),
        .cfg_interrupt_msi_sent            (msi_sent),
        .cfg_interrupt_msi_fail            (msi_fail)
    );

    always #5 user_clk = ~user_clk;

    always @(posedge user_clk) cyc <= cyc + 1;

    // Core model: answers each int pulse resp_delay cycles later for one cycle.
    initial begin
        msi_sent = 1'b0;
        msi_fail = 1'b0;
        forever begin
            @(negedge user_clk);
            if (msix_int && resp_mode != M_SILENT) begin
                repeat (resp_delay) @(posedge user_clk);
                #1;
                if (resp_mode == M_FAIL) begin
                    msi_fail = 1'b1;
                end else if (resp_mode == M_BOTH_ONCE && both_left > 0) begin
                    msi_sent = 1'b1;
                    msi_fail = 1'b1;
                    both_left--;
                end else begin
                    msi_sent = 1'b1;
                end
                @(posedge user_clk);
                #1;
                msi_sent = 1'b0;
                msi_fail = 1'b0;
            end
        end
    end

    // Monitor: every pulse and completion is popped from the scoreboard.
    always @(negedge user_clk) begin
        if (!user_reset) begin
            if (msix_int) begin
                pulse_total++;
                last_pulse_cyc = cyc;
                total++;
                if (pulse_q.size() == 0) begin
                    bad++;
                    $display("FAIL pulse_unexpected: got addr=%h data=%h func=%h, required no pulse",
                             msix_addr, msix_data, msix_func);
                end else begin
                    mon_msg = pulse_q.pop_front();
                    if ({msix_addr, msix_data, msix_func} !== {mon_msg.addr, mon_msg.data, mon_msg.func}) begin
                        bad++;
                        $display("FAIL pulse_msg: got %h/%h/%h, required %h/%h/%h", msix_addr, msix_data,
                                 msix_func, mon_msg.addr, mon_msg.data, mon_msg.func);
                    end
                end
            end
            if (done_vld) begin
                last_done_cyc = cyc;
                total++;
                if (done_q.size() == 0) begin
                    bad++;
                    $display("FAIL done_unexpected: got ch=%0d code=%0d, required no completion",
                             done_ch, done_code);
                end else begin
                    mon_cpl = done_q.pop_front();
                    if ({done_ch, done_code} !== {CH_W'(mon_cpl.ch), 2'(mon_cpl.code)}) begin
                        bad++;
                        $display("FAIL done_fields: got ch=%0d code=%0d, required ch=%0d code=%0d",
                                 done_ch, done_code, mon_cpl.ch, mon_cpl.code);
                    end
                end
            end
            if (req_rdy != '0) begin
                for (int i = 0; i < NUM_CH; i++) if (req_rdy[i]) grant_log.push_back(i);
                grant_cyc.push_back(cyc);
                total++;
                if (!$onehot(req_rdy)) begin
                    bad++;
                    $display("FAIL rdy_onehot: got req_rdy=%b, required one-hot", req_rdy);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge user_clk);
        #1;
    endtask

    function automatic msg_t mk_msg(input int ch);
        msg_t m;
        m.addr = 64'hFEE0_0000_0000_0000 + 64'(ch) * 64'h1000 + 64'h40;
        m.data = 32'hA500_0000 + 32'(ch) * 32'h101;
        m.func = FUNC_W'(ch * 3 + 1);
        return m;
    endfunction

    task automatic set_channel(input int ch, input msg_t m);
        req_addr[64*ch +: 64]         = m.addr;
        req_data[32*ch +: 32]         = m.data;
        req_func[FUNC_W*ch +: FUNC_W] = m.func;
    endtask

    task automatic wait_accept(input int ch, output int acc);
        int n = 0;
        bit ok = 1'b0;
        acc = -1;
        while (!ok && n < 64) begin
            @(negedge user_clk);
            n++;
            if (req_rdy[ch]) begin
                ok  = 1'b1;
                acc = cyc;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL accept_ch%0d: req_rdy=%b after %0d cycles, required bit %0d high", ch, req_rdy, n, ch);
        end
        step(1);
    endtask

    task automatic wait_quiet(input string name, input int max_cyc);
        int n = 0;
        while ((pulse_q.size() != 0 || done_q.size() != 0 || busy !== 1'b0) && n < max_cyc) begin
            @(negedge user_clk);
            n++;
        end
        total++;
        if (pulse_q.size() != 0 || done_q.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_drain: %0d pulses, %0d completions outstanding, busy=%b, required all drained",
                     name, pulse_q.size(), done_q.size(), busy);
        end
        step(1);
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if ({req_rdy, done_vld, done_ch, done_code, busy, msix_int} !== '0) begin
            bad++;
            $display("FAIL %s_ctrl: got rdy=%b done_vld=%b ch=%0d code=%0d busy=%b int=%b, required all 0",
                     name, req_rdy, done_vld, done_ch, done_code, busy, msix_int);
        end
        total++;
        if ({msix_addr, msix_data, msix_func} !== '0) begin
            bad++;
            $display("FAIL %s_msg: got %h/%h/%h, required 0/0/0", name, msix_addr, msix_data, msix_func);
        end
    endtask

    task automatic test_reset();
        user_reset  = 1'b1;
        req_vld     = '0;
        req_addr    = '0;
        req_data    = '0;
        req_func    = '0;
        msix_enable = 1'b1;
        msix_mask   = 1'b0;
        step(2);
        check_reset_outputs("reset");
        user_reset = 1'b0;
        step(2);
        total++;
        if (busy !== 1'b0 || req_rdy !== '0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%b rdy=%b, required 0/0", busy, req_rdy);
        end
    endtask

    task automatic test_round_robin();
        int base = grant_log.size();
        int n = 0;
        resp_mode  = M_SENT;
        resp_delay = 1;
        for (int i = 0; i < NUM_CH; i++) set_channel(i, mk_msg(i));
        for (int k = 0; k <= NUM_CH; k++) begin
            pulse_q.push_back(mk_msg(k % NUM_CH));
            done_q.push_back('{k % NUM_CH, int'(DONE_SENT)});
        end
        req_vld = '1;
        while (grant_log.size() - base < NUM_CH + 1 && n < 200) begin
            @(negedge user_clk);
            n++;
        end
        step(1);
        req_vld = '0;
        wait_quiet("rr", 200);
        total++;
        if (grant_log.size() - base !== NUM_CH + 1) begin
            bad++;
            $display("FAIL rr_count: got %0d grants, required %0d", grant_log.size() - base, NUM_CH + 1);
        end else begin
            for (int k = 0; k <= NUM_CH; k++) begin
                total++;
                if (grant_log[base+k] !== k % NUM_CH) begin
                    bad++;
                    $display("FAIL rr_order_%0d: got ch%0d, required ch%0d", k, grant_log[base+k], k % NUM_CH);
                end
            end
            total++;
            if (grant_cyc[base+1] - grant_cyc[base] !== 4) begin
                bad++;
                $display("FAIL rr_spacing: got %0d cycles between grants, required 4",
                         grant_cyc[base+1] - grant_cyc[base]);
            end
        end
    endtask

    task automatic test_single();
        msg_t m;
        int acc, p0;
        m.addr = 64'hFEE0_0000_0000_1000;
        m.data = 32'h0000_0055;
        m.func = 8'h12;
        resp_mode  = M_SENT;
        resp_delay = 3;
        p0 = pulse_total;
        set_channel(2, m);
        pulse_q.push_back(m);
        done_q.push_back('{2, int'(DONE_SENT)});
        req_vld[2] = 1'b1;
        wait_accept(2, acc);
        req_vld[2] = 1'b0;
        wait_quiet("single", 64);
        total++;
        if (last_pulse_cyc - acc !== 1) begin
            bad++;
            $display("FAIL single_int_lat: got %0d, required 1", last_pulse_cyc - acc);
        end
        total++;
        if (last_done_cyc - acc !== 5) begin
            bad++;
            $display("FAIL single_done_lat: got %0d, required 5", last_done_cyc - acc);
        end
        total++;
        if (pulse_total - p0 !== 1) begin
            bad++;
            $display("FAIL single_pulses: got %0d, required 1", pulse_total - p0);
        end
    endtask

    task automatic test_retry_fail();
        int acc, p0;
        resp_mode  = M_FAIL;
        resp_delay = 1;
        p0 = pulse_total;
        set_channel(5, mk_msg(5));
        for (int k = 0; k <= MAX_RETRY; k++) pulse_q.push_back(mk_msg(5));
        done_q.push_back('{5, int'(DONE_FAIL)});
        req_vld[5] = 1'b1;
        wait_accept(5, acc);
        req_vld[5] = 1'b0;
        wait_quiet("retry", 64);
        total++;
        if (pulse_total - p0 !== MAX_RETRY + 1) begin
            bad++;
            $display("FAIL retry_pulses: got %0d, required %0d", pulse_total - p0, MAX_RETRY + 1);
        end
        total++;
        if (last_done_cyc - acc !== 2 * MAX_RETRY + 3) begin
            bad++;
            $display("FAIL retry_done_lat: got %0d, required %0d", last_done_cyc - acc, 2 * MAX_RETRY + 3);
        end
    endtask

    task automatic test_timeout();
        int acc, p0;
        resp_mode = M_SILENT;
        p0 = pulse_total;
        set_channel(6, mk_msg(6));
        pulse_q.push_back(mk_msg(6));
        done_q.push_back('{6, int'(DONE_TIMEOUT)});
        req_vld[6] = 1'b1;
        wait_accept(6, acc);
        req_vld[6] = 1'b0;
        wait_quiet("timeout", 64);
        total++;
        if (last_done_cyc - last_pulse_cyc !== TIMEOUT + 1) begin
            bad++;
            $display("FAIL timeout_lat: got %0d cycles pulse-to-done, required %0d",
                     last_done_cyc - last_pulse_cyc, TIMEOUT + 1);
        end
        total++;
        if (pulse_total - p0 !== 1) begin
            bad++;
            $display("FAIL timeout_pulses: got %0d, required 1", pulse_total - p0);
        end
    endtask

    task automatic test_enable_mask();
        resp_mode  = M_SENT;
        resp_delay = 2;
        set_channel(1, mk_msg(1));
        pulse_q.push_back(mk_msg(1));
        done_q.push_back('{1, int'(DONE_SENT)});
        msix_enable = 1'b0;
        req_vld[1]  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                msix_enable = 1'b1;
                msix_mask   = 1'b1;
            end
            @(negedge user_clk);
            total++;
            if (req_rdy !== '0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL blocked_%0d: got rdy=%b busy=%b, required 0/0", k, req_rdy, busy);
            end
            step(1);
        end
        msix_mask = 1'b0;
        @(negedge user_clk);
        total++;
        if (req_rdy !== 8'b0000_0010) begin
            bad++;
            $display("FAIL unmask_grant: got rdy=%b, required 00000010", req_rdy);
        end
        step(1);
        req_vld[1] = 1'b0;
        msix_mask  = 1'b1;
        wait_quiet("mask_inflight", 64);
        msix_mask = 1'b0;
    endtask

    task automatic test_both();
        int acc, p0;
        resp_mode  = M_BOTH_ONCE;
        resp_delay = 1;
        both_left  = 1;
        p0 = pulse_total;
        set_channel(3, mk_msg(3));
        pulse_q.push_back(mk_msg(3));
        pulse_q.push_back(mk_msg(3));
        done_q.push_back('{3, int'(DONE_SENT)});
        req_vld[3] = 1'b1;
        wait_accept(3, acc);
        req_vld[3] = 1'b0;
        wait_quiet("both", 64);
        total++;
        if (pulse_total - p0 !== 2) begin
            bad++;
            $display("FAIL both_pulses: got %0d, required 2", pulse_total - p0);
        end
    endtask

    task automatic test_reset_in_wait();
        int acc, base, n;
        resp_mode = M_SILENT;
        set_channel(4, mk_msg(4));
        pulse_q.push_back(mk_msg(4));
        req_vld[4] = 1'b1;
        wait_accept(4, acc);
        req_vld[4] = 1'b0;
        step(2);
        user_reset = 1'b1;
        step(1);
        check_reset_outputs("rst_wait");
        user_reset = 1'b0;
        resp_mode  = M_SENT;
        resp_delay = 1;
        set_channel(0, mk_msg(0));
        set_channel(7, mk_msg(7));
        pulse_q.push_back(mk_msg(0));
        pulse_q.push_back(mk_msg(7));
        done_q.push_back('{0, int'(DONE_SENT)});
        done_q.push_back('{7, int'(DONE_SENT)});
        base = grant_log.size();
        req_vld = 8'b1000_0001;
        n = 0;
        while (grant_log.size() - base < 2 && n < 64) begin
            @(negedge user_clk);
            n++;
        end
        step(1);
        req_vld = '0;
        wait_quiet("post_reset", 64);
        total++;
        if (grant_log.size() - base !== 2) begin
            bad++;
            $display("FAIL post_reset_count: got %0d grants, required 2", grant_log.size() - base);
        end else begin
            total++;
            if (grant_log[base] !== 0 || grant_log[base+1] !== 7) begin
                bad++;
                $display("FAIL post_reset_order: got ch%0d,ch%0d, required ch0,ch7",
                         grant_log[base], grant_log[base+1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_retry_fail();
        test_timeout();
        test_enable_mask();
        test_both();
        test_reset_in_wait();
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
